// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of the low w bits of x; the most negative value maps to 2^(w-1) exactly.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input logic sgn,
                                               input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sign_sh;
        mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        sign_sh = x >> (w - 1);
        if (sgn && sign_sh[0]) begin
            return (~x + MAX_W'(1)) & mask;
        end
        return x & mask;
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder with carry-out, chained from full adder cells.
module ripple_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fulladder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: one partial product per cycle, signed via
// magnitudes plus a final conditional negate.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t              state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic                neg;
    logic [2*WIDTH-1:0]  acc;
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH:0]      add_a;
    logic [WIDTH:0]      add_b;
    logic [WIDTH:0]      add_sum;
    logic                add_cout;
    logic [2*WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]    mplier_d;

    // Adding {mcand,0} into acc[2W-1:W-1] weights mcand at 2^W; bit 0 of the sum is acc[W-1].
    assign add_a = acc[2*WIDTH-1:WIDTH-1];
    assign add_b = mplier[0] ? {mcand, 1'b0} : '0;

    ripple_adder #(
        .N(WIDTH + 1)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_comb begin
        acc_d    = '0;
        mplier_d = '0;
        {acc_d, mplier_d} = {add_cout, add_sum, acc[WIDTH-2:0], mplier[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= WIDTH'(abs_w(MAX_W'(a), is_signed, WIDTH));
                        mplier   <= WIDTH'(abs_w(MAX_W'(b), is_signed, WIDTH));
                        neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        // A zero magnitude is never negated, so no -0 can appear.
                        product   <= (neg && (acc != '0)) ? -acc : acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc    <= acc_d;
                        mplier <= mplier_d;
                        cnt    <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
